dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester (CPU, DMA/debug) arbiter in front of a single-port data memory.
// Round-robin on ties; each access is a fixed three-cycle grant/access/response sequence.
module dmem_arbiter #(
  parameter int bits       = 64,
  parameter int addr_width = 10
) (
  input  logic                  clk,
  input  logic                  async_reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [2:0]            cpu_ctrl,
  input  logic [addr_width-1:0] cpu_addr,
  input  logic [bits-1:0]       cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [bits-1:0]       cpu_rdata,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [2:0]            dma_ctrl,
  input  logic [addr_width-1:0] dma_addr,
  input  logic [bits-1:0]       dma_wdata,
  output logic                  dma_gnt,
  output logic                  dma_rvalid,
  output logic [bits-1:0]       dma_rdata,
  output logic [2:0]            mem_control,
  output logic [bits-1:0]       mem_data,
  output logic [addr_width-1:0] mem_addr,
  output logic                  mem_we,
  input  logic [bits-1:0]       mem_q
);

  if ((bits % 8) != 0 || bits < 32) begin : gBadParam
    $error("dmem_arbiter: bits must be a multiple of 8 and at least 32");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e                state_q, state_d;
  logic                  lastGrantDma_q;
  logic                  ownerDma_q;
  logic                  we_q;
  logic [2:0]            ctrl_q;
  logic [addr_width-1:0] addr_q;
  logic [bits-1:0]       wdata_q;
  logic [bits-1:0]       cpuRdata_q, dmaRdata_q;
  logic                  cpuRvalid_q, dmaRvalid_q;
  logic                  grantCpu, grantDma;

  // Ties go to whoever was not served last; nothing is granted while reset is high.
  always_comb begin
    state_d  = state_q;
    grantCpu = 1'b0;
    grantDma = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!async_reset) begin
          if (cpu_req && (!dma_req || lastGrantDma_q)) begin
            grantCpu = 1'b1;
          end else if (dma_req) begin
            grantDma = 1'b1;
          end
        end
        if (grantCpu || grantDma) begin
          state_d = ACCESS;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (async_reset) begin
      state_q        <= IDLE;
      lastGrantDma_q <= 1'b1;
      ownerDma_q     <= 1'b0;
      we_q           <= 1'b0;
      ctrl_q         <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      cpuRdata_q     <= '0;
      dmaRdata_q     <= '0;
      cpuRvalid_q    <= 1'b0;
      dmaRvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cpuRvalid_q <= 1'b0;
      dmaRvalid_q <= 1'b0;
      if (grantCpu || grantDma) begin
        lastGrantDma_q <= grantDma;
        ownerDma_q     <= grantDma;
        we_q           <= grantDma ? dma_we    : cpu_we;
        ctrl_q         <= grantDma ? dma_ctrl  : cpu_ctrl;
        addr_q         <= grantDma ? dma_addr  : cpu_addr;
        wdata_q        <= grantDma ? dma_wdata : cpu_wdata;
      end
      // Read data is captured on the ACCESS->RESP edge; only the owner's copy moves.
      if (state_q == ACCESS && !we_q) begin
        if (ownerDma_q) begin
          dmaRdata_q  <= mem_q;
          dmaRvalid_q <= 1'b1;
        end else begin
          cpuRdata_q  <= mem_q;
          cpuRvalid_q <= 1'b1;
        end
      end
    end
  end

  assign cpu_gnt     = grantCpu;
  assign dma_gnt     = grantDma;
  assign cpu_rvalid  = cpuRvalid_q & ~async_reset;
  assign dma_rvalid  = dmaRvalid_q & ~async_reset;
  assign cpu_rdata   = cpuRdata_q;
  assign dma_rdata   = dmaRdata_q;
  assign mem_we      = (state_q == ACCESS) & we_q;
  assign mem_control = (state_q == ACCESS) ? ctrl_q  : '0;
  assign mem_addr    = (state_q == ACCESS) ? addr_q  : '0;
  assign mem_data    = (state_q == ACCESS) ? wdata_q : '0;

endmodule
